seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the hex-to-7-segment decoder: snoops a scanned, multiplexed 7-seg
//  display bus (active-low segments + active-low one-hot digit anodes). Decodes each lit digit
//  back to a hex nibble and assembles a full frame. Presents the frame via valid/ready handshake.
//  Sits between the display driver and the self-check/debug logic of the ALU lab top level.
// PARAMETERS
//  DIGITS       8       number of scanned digits (2..8); frame width = 4*DIGITS bits
//  SETTLE_CYC   4       consecutive stable cycles of anode+segment bus before a digit is sampled (1..255)
//  TIMEOUT_CYC  65535   cycles without any digit capture before the partial frame is dropped (16-bit)
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  an_n         in   DIGITS     digit enables, active-low, one-hot-low when a digit is driven
//  seg_n        in   8          {p,g,f,e,d,c,b,a}, active-low segments; p = decimal point
//  frame_hex    out  4*DIGITS   decoded nibbles, digit i at [4i+3:4i]
//  frame_dp     out  DIGITS     decimal point lit per digit
//  frame_blank  out  DIGITS     digit had all segments a..g off
//  frame_err    out  DIGITS     digit pattern not in the 16-entry table
//  frame_valid  out  1          frame pending
//  frame_ready  in   1          consumer accepts frame when frame_valid & frame_ready
//  overrun      out  1          sticky: frame completed while previous still pending; clears on accept
//  stale        out  1          sticky: timeout fired; clears when next frame completes
// BEHAVIOUR
//  - Reset: all outputs 0. Capture mask 0. Settle and timeout counters 0.
//  - Input sync: an_n and seg_n pass through 2 flops before any use (2-cycle input latency).
//  - Settle: a digit is eligible when synced an_n has exactly one 0 bit.
//    Settle counter increments while {an_n,seg_n} equals its previous cycle value and is eligible.
//    It resets to 0 on any change or when the bus is ineligible.
//    On reaching SETTLE_CYC, sample once; no re-sample until the bus changes.
//  - Decode seg_n[6:0] (gfedcba, active-low):
//      0:40  1:79  2:24  3:30  4:19  5:12  6:02  7:78
//      8:00  9:10  A:08  b:03  C:46  d:21  E:06  F:0E (hex)
//    7F: blank=1, nibble 0. Any other pattern: err=1, nibble 0. dp = ~seg_n[7].
//  - Sample writes the working slot for digit i and sets mask[i]. Re-capturing a digit before the
//    frame completes overwrites the slot and does not double-count.
//  - Frame complete: cycle after mask becomes all-ones.
//    Working slots copy to frame_* outputs, mask clears, frame_valid=1, stale clears.
//    If frame_valid was already 1 and not accepted this cycle, frame_* are still overwritten and
//    overrun=1. frame_valid stays 1.
//  - Handshake: frame_valid holds with frame_* stable until frame_valid & frame_ready.
//    Then frame_valid drops next cycle and overrun clears. Completion and accept in the same cycle
//    give new data with frame_valid=1 and no overrun.
//  - Timeout: counter clears on every sample and otherwise increments.
//    At TIMEOUT_CYC: mask clears, stale=1, counter clears. frame_valid and frame_* are untouched.
//  - Reset mid-frame: partial frame discarded; pending frame lost.
//  - Total latency from a digit becoming stable to capture: 2 + SETTLE_CYC cycles.
// CONFIGURATION
//  SEG7_SCAN_DECODER_ERRCNT_EN defined:
//    adds output err_count [15:0]. It increments on each sample decoded with err=1 and saturates at
//    FFFF. Reset to 0 by rst only.
//  Not defined: no err_count port, no counter logic; all other behaviour identical.
// TESTING
//  1. DIGITS=8. Drive digits 0..7 with patterns for 0,1,2,3,4,5,6,7, each held 10 cycles, dp off
//     -> frame_hex=76543210, frame_valid=1, frame_err=0, frame_blank=0.
//  2. Same frame, but digit 3 = 7F and digit 5 = 7E with dp lit (seg_n=0x7E)
//     -> frame_blank=08, frame_err=20, frame_dp=20, nibbles 3 and 5 = 0.
//  3. Hold frame_ready=0 and complete two frames (89ABCDEF then 01234567)
//     -> frame_hex=01234567, overrun=1. Raise frame_ready 1 cycle -> valid=0 and overrun=0 next cycle.
//  4. Glitch: change seg_n every 2 cycles with SETTLE_CYC=4 -> no capture, mask stays 0, no frame.
//  5. Capture 5 digits, then idle with TIMEOUT_CYC=100 -> stale=1 at 100 cycles after the last sample.
//     Next full frame completes -> stale=0.
//  6. Assert rst asynchronously mid-frame, with frame_valid=1 -> all outputs 0 immediately.
//     With ERRCNT_EN, 3 bad patterns then a full frame -> err_count=3.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Snoops a scanned, multiplexed active-low 7-segment bus and rebuilds whole hex frames for a
// valid/ready consumer. Optional macro SEG7_SCAN_DECODER_ERRCNT_EN adds a saturating err_count.
module seg7_scan_decoder #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [7:0]            seg_n,
  output logic [4*DIGITS-1:0]   frame_hex,
  output logic [DIGITS-1:0]     frame_dp,
  output logic [DIGITS-1:0]     frame_blank,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun,
  output logic                  stale
`ifdef SEG7_SCAN_DECODER_ERRCNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  localparam logic [8:0]  SETTLE_W  = 9'(SETTLE_CYC);
  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT_CYC);

  logic [DIGITS-1:0]   an_s1_q, an_s2_q;
  logic [7:0]          seg_s1_q, seg_s2_q;
  logic [DIGITS+7:0]   bus_prev_q;
  logic [7:0]          settle_q, settle_d;
  logic                sampled_q, sampled_d;
  logic [15:0]         tmo_q, tmo_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [4*DIGITS-1:0] hex_w_q, hex_w_d;
  logic [DIGITS-1:0]   dp_w_q, dp_w_d, blank_w_q, blank_w_d, err_w_q, err_w_d;
  logic [4*DIGITS-1:0] hex_q, hex_d;
  logic [DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d, err_q, err_d;
  logic                valid_q, valid_d, overrun_q, overrun_d, stale_q, stale_d;

  logic                eligible, stable, sample, complete, accept, tmo_fire;
  logic [3:0]          dec_nib;
  logic                dec_blank, dec_err, dec_dp;

  assign eligible = $onehot(~an_s2_q);
  assign stable   = ({an_s2_q, seg_s2_q} == bus_prev_q);

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_s2_q[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  assign dec_dp = ~seg_s2_q[7];

  // One sample per stable stretch: sampled_q blocks re-capture until the bus moves.
  always_comb begin
    settle_d  = '0;
    sampled_d = 1'b0;
    sample    = 1'b0;
    if (eligible && stable) begin
      sampled_d = sampled_q;
      if (!sampled_q) begin
        if ({1'b0, settle_q} + 9'd1 == SETTLE_W) begin
          sample    = 1'b1;
          sampled_d = 1'b1;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
    end
  end

  // Handshake: frame_valid with frame_* held stable until a cycle where frame_valid &
  // frame_ready; the frame is consumed on that edge. A new frame may replace a pending one.
  always_comb begin
    complete  = &mask_q;
    accept    = valid_q & frame_ready;
    tmo_fire  = !sample && ({1'b0, tmo_q} + 17'd1 == TIMEOUT_W);

    hex_w_d   = hex_w_q;
    dp_w_d    = dp_w_q;
    blank_w_d = blank_w_q;
    err_w_d   = err_w_q;
    mask_d    = mask_q;
    tmo_d     = tmo_q + 16'd1;
    hex_d     = hex_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    err_d     = err_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    stale_d   = stale_q;

    if (complete || tmo_fire) mask_d = '0;
    if (sample || tmo_fire)   tmo_d  = '0;

    if (sample) begin
      mask_d = mask_d | ~an_s2_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (!an_s2_q[i]) begin
          hex_w_d[4*i +: 4] = dec_nib;
          dp_w_d[i]         = dec_dp;
          blank_w_d[i]      = dec_blank;
          err_w_d[i]        = dec_err;
        end
      end
    end

    if (tmo_fire) stale_d = 1'b1;
    if (accept) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (complete) begin
      hex_d   = hex_w_q;
      dp_d    = dp_w_q;
      blank_d = blank_w_q;
      err_d   = err_w_q;
      valid_d = 1'b1;
      stale_d = 1'b0;
      if (valid_q && !accept) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1_q    <= '1;
      an_s2_q    <= '1;
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      bus_prev_q <= '1;
      settle_q   <= '0;
      sampled_q  <= 1'b0;
      tmo_q      <= '0;
      mask_q     <= '0;
      hex_w_q    <= '0;
      dp_w_q     <= '0;
      blank_w_q  <= '0;
      err_w_q    <= '0;
      hex_q      <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      err_q      <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      an_s1_q    <= an_n;
      an_s2_q    <= an_s1_q;
      seg_s1_q   <= seg_n;
      seg_s2_q   <= seg_s1_q;
      bus_prev_q <= {an_s2_q, seg_s2_q};
      settle_q   <= settle_d;
      sampled_q  <= sampled_d;
      tmo_q      <= tmo_d;
      mask_q     <= mask_d;
      hex_w_q    <= hex_w_d;
      dp_w_q     <= dp_w_d;
      blank_w_q  <= blank_w_d;
      err_w_q    <= err_w_d;
      hex_q      <= hex_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      stale_q    <= stale_d;
    end
  end

  assign frame_hex   = hex_q;
  assign frame_dp    = dp_q;
  assign frame_blank = blank_q;
  assign frame_err   = err_q;
  assign frame_valid = valid_q;
  assign overrun     = overrun_q;
  assign stale       = stale_q;

`ifdef SEG7_SCAN_DECODER_ERRCNT_EN
  logic [15:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (sample && dec_err && errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) errcnt_q <= '0;
    else     errcnt_q <= errcnt_d;
  end

  assign err_count = errcnt_q;
`endif

endmodule
